// File: rtl/reg_file.sv
// TTL16 register file: 16 x 16-bit registers, one write port, two combinational read ports.
// Define REG_FILE_BYPASS_EN to forward DIN to a read port that selects the register being written.

module reg_file_slot (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] d,
    output logic [15:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= 16'h0000;
        else if (en)
            q <= d;
    end
endmodule

module reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  WSEL,
    input  logic        W,
    input  logic [15:0] DIN,
    input  logic [3:0]  RSEL0,
    input  logic [3:0]  RSEL1,
    output logic [15:0] DOUT0,
    output logic [15:0] DOUT1
);
    localparam int NUM_REGS = 16;
    localparam int DW       = 16;

    logic [NUM_REGS-1:0]         wen;
    logic [NUM_REGS-1:0]         sel0_oh;
    logic [NUM_REGS-1:0]         sel1_oh;
    logic [NUM_REGS-1:0][DW-1:0] regs;
    logic [DW-1:0]               rd0;
    logic [DW-1:0]               rd1;

    // one-hot write decode, all lines low when W is low
    assign wen     = W ? (NUM_REGS'(1) << WSEL) : '0;
    assign sel0_oh = NUM_REGS'(1) << RSEL0;
    assign sel1_oh = NUM_REGS'(1) << RSEL1;

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_slot
            reg_file_slot u_slot (
                .clk (clk),
                .rst (rst),
                .en  (wen[g]),
                .d   (DIN),
                .q   (regs[g])
            );
        end
    endgenerate

    // AND-OR read muxes
    always_comb begin
        rd0 = '0;
        rd1 = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd0 = rd0 | (regs[i] & {DW{sel0_oh[i]}});
            rd1 = rd1 | (regs[i] & {DW{sel1_oh[i]}});
        end
    end

`ifdef REG_FILE_BYPASS_EN
    assign DOUT0 = (W && (RSEL0 == WSEL)) ? DIN : rd0;
    assign DOUT1 = (W && (RSEL1 == WSEL)) ? DIN : rd1;
`else
    assign DOUT0 = rd0;
    assign DOUT1 = rd1;
`endif
endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, write/readback, hold, isolation, dual read, bypass.
`timescale 1ns/1ps

module tb_reg_file;
    logic        clk;
    logic        rst;
    logic [3:0]  WSEL;
    logic        W;
    logic [15:0] DIN;
    logic [3:0]  RSEL0;
    logic [3:0]  RSEL1;
    logic [15:0] DOUT0;
    logic [15:0] DOUT1;

    int checks = 0;
    int fails  = 0;
    logic [15:0] mdl [16];

    reg_file dut (
        .clk   (clk),
        .rst   (rst),
        .WSEL  (WSEL),
        .W     (W),
        .DIN   (DIN),
        .RSEL0 (RSEL0),
        .RSEL1 (RSEL1),
        .DOUT0 (DOUT0),
        .DOUT1 (DOUT1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected read value given the model and current write-port inputs
    function automatic logic [15:0] exp_rd(input logic [3:0] sel);
`ifdef REG_FILE_BYPASS_EN
        if (W && sel == WSEL && !rst) return DIN;
`endif
        return mdl[sel];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] sel, input logic [15:0] d);
        WSEL = sel; DIN = d; W = 1'b1;
        @(posedge clk);
        mdl[sel] = d;
        #1;
        W = 1'b0;
    endtask

    task automatic chk_both(input string tag);
        #1;
        chk({tag, "_p0"}, DOUT0, exp_rd(RSEL0));
        chk({tag, "_p1"}, DOUT1, exp_rd(RSEL1));
    endtask

    initial begin
        logic [15:0] pats [6];
        pats[0] = 16'h0000; pats[1] = 16'hFFFF; pats[2] = 16'hA5A5;
        pats[3] = 16'h5A5A; pats[4] = 16'h0001; pats[5] = 16'h8000;
        for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
        rst = 1'b1; W = 1'b0; WSEL = 4'd0; DIN = 16'h0; RSEL0 = 4'd0; RSEL1 = 4'd15;

        // reset state
        #7;
        chk("rst_init_p0", DOUT0, 16'h0000);
        chk("rst_init_p1", DOUT1, 16'h0000);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // async reset mid-cycle, no clock edge
        wr(4'd5, 16'h1234);
        RSEL0 = 4'd5; #1;
        chk("r5_written", DOUT0, 16'h1234);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_r5", DOUT0, 16'h0000);
        for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            RSEL0 = 4'(i); RSEL1 = 4'(15 - i); #1;
            chk("rst_sweep_p0", DOUT0, 16'h0000);
            chk("rst_sweep_p1", DOUT1, 16'h0000);
        end
        // reset beats a simultaneous write
        WSEL = 4'd9; DIN = 16'hBEEF; W = 1'b1;
        @(posedge clk); #1;
        W = 1'b0; RSEL0 = 4'd9; #1;
        chk("rst_prio", DOUT0, 16'h0000);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // write/readback sweep, other port parked on R2
        for (int r = 0; r < 16; r++) begin
            for (int p = 0; p < 6; p++) begin
                wr(4'(r), pats[p] ^ 16'(r));
                if (r[0]) begin RSEL1 = 4'(r); RSEL0 = 4'd2; end
                else      begin RSEL0 = 4'(r); RSEL1 = 4'd2; end
                #1;
                chk("sweep_sel", r[0] ? DOUT1 : DOUT0, pats[p] ^ 16'(r));
                chk("sweep_r2",  r[0] ? DOUT0 : DOUT1, mdl[2]);
            end
        end

        // hold: W stays high, register follows DIN only at edges
        RSEL0 = 4'd7; RSEL1 = 4'd7;
        WSEL = 4'd7; DIN = 16'hFFFF; W = 1'b1;
        @(posedge clk); mdl[7] = 16'hFFFF; #1;
        chk_both("hold_ffff");
        DIN = 16'h0F0F; #2;
        chk_both("hold_mid");
        @(posedge clk); mdl[7] = 16'h0F0F; #1;
        chk_both("hold_edge");
        DIN = 16'hFFFF;
        @(posedge clk); mdl[7] = 16'hFFFF; #1;
        W = 1'b0; DIN = 16'h0000;
        @(posedge clk); #1;
        DIN = 16'h1357; #1;
        chk("hold_w0_p0", DOUT0, 16'hFFFF);
        chk("hold_w0_p1", DOUT1, 16'hFFFF);

        // isolation
        for (int i = 0; i < 16; i++) wr(4'(i), 16'($urandom));
        for (int i = 0; i < 16; i++) begin
            RSEL0 = 4'(i); RSEL1 = 4'($urandom_range(0, 15));
            chk_both("iso_a");
        end
        for (int i = 0; i < 16; i++) begin
            RSEL1 = 4'(i); RSEL0 = 4'($urandom_range(0, 15));
            chk_both("iso_b");
        end

        // dual read of the same register
        for (int k = 0; k < 16; k++) begin
            RSEL0 = 4'(k); RSEL1 = 4'(k); #1;
            chk("dual_p0", DOUT0, mdl[k]);
            chk("dual_p1", DOUT1, mdl[k]);
        end

        // read during write, forwarding depends on build
        wr(4'd3, 16'h00AA);
        RSEL0 = 4'd3; RSEL1 = 4'd4;
        WSEL = 4'd3; DIN = 16'h5555; W = 1'b1; #1;
`ifdef REG_FILE_BYPASS_EN
        chk("bypass_pre", DOUT0, 16'h5555);
`else
        chk("bypass_pre", DOUT0, 16'h00AA);
`endif
        chk("bypass_other", DOUT1, mdl[4]);
        @(posedge clk); mdl[3] = 16'h5555; #1;
        W = 1'b0; #1;
        chk("bypass_post", DOUT0, 16'h5555);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
